readout_accum: RTL
==================

# readout_accum

Parametrised multi-channel readout integrator for the qubit readout chain. It replaces the fixed single-qubit timing and integration pair with one block. It sits after the multiplier stage and consumes counter-rotated I/Q lanes for `NCH` readout channels. On a trigger it waits a programmable delay, then integrates a programmable number of beats. Results can be accumulated over multiple shots (averaging mode) before one `iq_valid` pulse is raised.

## Interface
- `LANES`, 5, samples per channel per clock
- `NCH`, 2, independent readout channels
- `IN_W`, 32, signed width of each rotated sample
- `ACC_W`, 48, signed accumulator/result width
- `DELAY_W`, 14, delay counter width
- `LEN_W`, 11, sample-length width (beats)
- `SHOT_W`, 8, shot-count width

- `clk100`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `trigger`  in  1  level input; rising edge detected internally
- `delay_time`  in  DELAY_W  beats from trigger edge to first collected beat
- `sample_length`  in  LEN_W  beats integrated per shot
- `num_shots`  in  SHOT_W  shots summed per result; 0 treated as 1
- `data_i_rot`, `data_q_rot`  in  NCH×LANES×IN_W  signed rotated samples
- `thresh_i`  in  NCH×ACC_W  signed discrimination threshold (used only with macro)
- `busy`  out  1  high in any state other than IDLE
- `overrun`  out  1  one-cycle pulse: trigger edge while not accepting
- `iq_valid`  out  1  one-cycle result strobe
- `i_val`, `q_val`  out  NCH×ACC_W  signed summed results, held until next strobe
- `state_bit`  out  NCH  per-channel discrimination result

## Operation
- FSM states:
  - IDLE: trigger edge latches `delay_time`, `sample_length` and `num_shots`, clears the accumulators and shot counter, then goes to DELAY (or COLLECT if delay is 0).
  - DELAY: counts down the latched delay, then goes to COLLECT.
  - COLLECT: accumulates `sample_length` beats, then goes to ARMED if shots remain, else FLUSH.
  - ARMED: trigger edge goes to DELAY (or COLLECT) without clearing the accumulators or the config.
  - FLUSH: waits for the pipeline to drain, pulses `iq_valid`, then goes to IDLE.
- Arithmetic:
  - Each beat, per channel and per component, the `LANES` samples are sign-extended to ACC_W and summed.
  - The sum is added to the accumulator.
  - Two's-complement wraparound; no saturation. Sizing ACC_W is the integrator's responsibility.
- `sample_length` = 0: no beats collected; the shot still counts. Result is 0 when every shot has length 0.
- Trigger edge in DELAY, COLLECT or FLUSH: ignored, `overrun` pulses. Config inputs are ignored outside IDLE/ARMED edges.
- Reset mid-operation: every output and register clears immediately; the FSM returns to IDLE.

## Timing
- Reset values:
  - `busy`, `overrun`, `iq_valid`, `state_bit` = 0.
  - `i_val`, `q_val` = 0.
  - FSM = IDLE, all counters 0.
- Trigger edge is detected on the cycle `trigger` is first sampled high (cycle T).
- With D = delay and L = length, the collected beats are those presented on cycles T+1+D … T+D+L.
- Pipeline: lane sum registered at +1, accumulator at +2, outputs registered at +3.
  - `iq_valid` is high exactly one cycle, 3 cycles after the last collected beat of the final shot.
  - For L=0, `iq_valid` is high 3 cycles after the final trigger edge.
- `busy` rises the cycle after T and falls together with `iq_valid`.
- New results update `i_val`/`q_val` on the same cycle as `iq_valid`.

## Configuration
- `READOUT_THRESH_EN`:
  - Defined: on the strobe cycle, `state_bit[c]` = (`i_val[c]` > `thresh_i[c]`), registered alongside `iq_valid` and held until the next strobe.
  - Undefined: the comparator is not built; `state_bit` is tied to 0 and `thresh_i` is unused.

## Structure
- `readout_pkg`: FSM state enum (IDLE, DELAY, COLLECT, ARMED, FLUSH), default width localparams, and a `PIPE_LAT` = 3 constant shared with the bench.
- Sub-module `lane_adder_tree`:
  - Parametrised LANES-input signed adder with one output register.
  - Instantiated 2×NCH times.

## Test plan
- Reset, D=0, L=1, shots=1, all lanes = 1 on both channels, trigger at T → `i_val`=`q_val`=5 per channel; `iq_valid` at T+4; `busy` high T+1..T+4.
- D=10, L=100, shots=1, channel 0 I lanes = −3, channel 1 Q lanes = 7 → I0 = −1500, Q1 = 3500, others 0; `iq_valid` at T+113.
- shots=4, L=8, lanes = 2, triggers spaced 50 cycles apart → a single `iq_valid` after the 4th shot with value 320; no strobe after shots 1–3.
- Trigger re-asserted during COLLECT → `overrun` one-cycle pulse; result and timing identical to the undisturbed run.
- `reset` asserted mid-COLLECT → all outputs 0 next edge; a fresh trigger produces a correct result with no carryover.
- With `READOUT_THRESH_EN`, `thresh_i[0]`=100, I0 result 101 then 100 → `state_bit[0]` = 1 then 0; without the macro it is always 0.

Source files
------------

// File: rtl/readout_accum_pkg.sv
// Shared types and defaults for the multi-channel readout integrator.
package readout_pkg;

    localparam int unsigned DEF_LANES   = 5;
    localparam int unsigned DEF_NCH     = 2;
    localparam int unsigned DEF_IN_W    = 32;
    localparam int unsigned DEF_ACC_W   = 48;
    localparam int unsigned DEF_DELAY_W = 14;
    localparam int unsigned DEF_LEN_W   = 11;
    localparam int unsigned DEF_SHOT_W  = 8;

    // Cycles from the last collected beat to the result strobe.
    localparam int unsigned PIPE_LAT = 3;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        COLLECT,
        ARMED,
        FLUSH
    } state_t;

endpackage

// File: rtl/readout_accum_if.sv
// Trigger/config/sample/result bundle between the multiplier stage and the integrator.
interface readout_accum_if
    import readout_pkg::*;
#(
    parameter int unsigned LANES   = DEF_LANES,
    parameter int unsigned NCH     = DEF_NCH,
    parameter int unsigned IN_W    = DEF_IN_W,
    parameter int unsigned ACC_W   = DEF_ACC_W,
    parameter int unsigned DELAY_W = DEF_DELAY_W,
    parameter int unsigned LEN_W   = DEF_LEN_W,
    parameter int unsigned SHOT_W  = DEF_SHOT_W
);
    logic                        trigger;
    logic [DELAY_W-1:0]          delay_time;
    logic [LEN_W-1:0]            sample_length;
    logic [SHOT_W-1:0]           num_shots;
    logic [NCH*LANES*IN_W-1:0]   data_i_rot;
    logic [NCH*LANES*IN_W-1:0]   data_q_rot;
    logic [NCH*ACC_W-1:0]        thresh_i;
    logic                        busy;
    logic                        overrun;
    logic                        iq_valid;
    logic [NCH*ACC_W-1:0]        i_val;
    logic [NCH*ACC_W-1:0]        q_val;
    logic [NCH-1:0]              state_bit;

    modport master (
        output trigger, delay_time, sample_length, num_shots,
               data_i_rot, data_q_rot, thresh_i,
        input  busy, overrun, iq_valid, i_val, q_val, state_bit
    );

    modport slave (
        input  trigger, delay_time, sample_length, num_shots,
               data_i_rot, data_q_rot, thresh_i,
        output busy, overrun, iq_valid, i_val, q_val, state_bit
    );

endinterface

// File: rtl/readout_accum_lane_adder_tree.sv
// Sums LANES signed samples, sign-extended to ACC_W, into one registered result.
module lane_adder_tree #(
    parameter int unsigned LANES = 5,
    parameter int unsigned IN_W  = 32,
    parameter int unsigned ACC_W = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LANES*IN_W-1:0]    din,
    output logic signed [ACC_W-1:0]  sum
);

    logic signed [ACC_W-1:0] total;

    always_comb begin
        total = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            total = total + ACC_W'($signed(din[l*IN_W +: IN_W]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else begin
            sum <= total;
        end
    end

endmodule

// File: rtl/readout_accum.sv
// Multi-channel, multi-shot I/Q readout integrator (trigger -> delay -> collect -> flush).
// Optional discriminator enabled by defining READOUT_THRESH_EN.
module readout_accum
    import readout_pkg::*;
#(
    parameter int unsigned LANES   = DEF_LANES,
    parameter int unsigned NCH     = DEF_NCH,
    parameter int unsigned IN_W    = DEF_IN_W,
    parameter int unsigned ACC_W   = DEF_ACC_W,
    parameter int unsigned DELAY_W = DEF_DELAY_W,
    parameter int unsigned LEN_W   = DEF_LEN_W,
    parameter int unsigned SHOT_W  = DEF_SHOT_W
) (
    input  logic           clk100,
    input  logic           reset,
    readout_accum_if.slave io
);

    state_t               state, next_state;
    logic                 trig_prev, trig_edge;
    logic [DELAY_W-1:0]   dly_cfg, dly_cnt, cfg_dly;
    logic [LEN_W-1:0]     len_cfg, len_cnt, cfg_len;
    logic [SHOT_W-1:0]    shots_cfg, shot_cnt, cfg_shots, done_shots;
    logic [SHOT_W:0]      shots_next;
    logic                 last_shot;
    logic [1:0]           flush_cnt;
    logic                 busy_c, beat, start, clear_acc, shot_done, load_out, ovr;
    logic                 beat_d1, overrun_r, iq_valid_r;
    logic signed [ACC_W-1:0] sum_i [NCH];
    logic signed [ACC_W-1:0] sum_q [NCH];
    logic signed [ACC_W-1:0] acc_i [NCH];
    logic signed [ACC_W-1:0] acc_q [NCH];
    logic [NCH*ACC_W-1:0] i_val_r, q_val_r;

    assign trig_edge = io.trigger & ~trig_prev;

    // An IDLE edge acts on the live config inputs; an ARMED edge reuses the latched ones.
    always_comb begin
        cfg_dly    = dly_cfg;
        cfg_len    = len_cfg;
        cfg_shots  = shots_cfg;
        done_shots = shot_cnt;
        if (state == IDLE) begin
            cfg_dly    = io.delay_time;
            cfg_len    = io.sample_length;
            cfg_shots  = (io.num_shots == '0) ? SHOT_W'(1) : io.num_shots;
            done_shots = '0;
        end
    end

    assign shots_next = {1'b0, done_shots} + 1'b1;
    assign last_shot  = shots_next >= {1'b0, cfg_shots};

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A zero-length shot skips the delay entirely so its result strobes PIPE_LAT after the edge.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, ARMED: begin
                if (trig_edge) begin
                    if (cfg_len == '0)      next_state = last_shot ? FLUSH : ARMED;
                    else if (cfg_dly == '0) next_state = COLLECT;
                    else                    next_state = DELAY;
                end
            end
            DELAY:   if (dly_cnt == DELAY_W'(1)) next_state = COLLECT;
            COLLECT: if (len_cnt == LEN_W'(1))   next_state = last_shot ? FLUSH : ARMED;
            FLUSH:   if (flush_cnt == '0)        next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_c    = (state != IDLE);
        beat      = (state == COLLECT);
        start     = trig_edge && ((state == IDLE) || (state == ARMED));
        clear_acc = trig_edge && (state == IDLE);
        shot_done = (beat && (len_cnt == LEN_W'(1))) || (start && (cfg_len == '0));
        load_out  = (state == FLUSH) && (flush_cnt == 2'd1);
        ovr       = trig_edge && ((state == DELAY) || (state == COLLECT) || (state == FLUSH));
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            trig_prev <= 1'b0;
            dly_cfg   <= '0;
            len_cfg   <= '0;
            shots_cfg <= '0;
            dly_cnt   <= '0;
            len_cnt   <= '0;
            shot_cnt  <= '0;
            flush_cnt <= '0;
            beat_d1   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            trig_prev <= io.trigger;
            beat_d1   <= beat;
            overrun_r <= ovr;
            if (start) begin
                if (state == IDLE) begin
                    dly_cfg   <= io.delay_time;
                    len_cfg   <= io.sample_length;
                    shots_cfg <= cfg_shots;
                end
                dly_cnt <= cfg_dly;
                len_cnt <= cfg_len;
            end else begin
                if (state == DELAY)   dly_cnt <= dly_cnt - 1'b1;
                if (state == COLLECT) len_cnt <= len_cnt - 1'b1;
            end
            if (shot_done)      shot_cnt <= shots_next[SHOT_W-1:0];
            else if (clear_acc) shot_cnt <= '0;
            if ((next_state == FLUSH) && (state != FLUSH)) flush_cnt <= 2'(PIPE_LAT - 1);
            else if ((state == FLUSH) && (flush_cnt != '0)) flush_cnt <= flush_cnt - 1'b1;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        lane_adder_tree #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W)) u_add_i (
            .clk (clk100),
            .rst (reset),
            .din (io.data_i_rot[c*LANES*IN_W +: LANES*IN_W]),
            .sum (sum_i[c])
        );
        lane_adder_tree #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W)) u_add_q (
            .clk (clk100),
            .rst (reset),
            .din (io.data_q_rot[c*LANES*IN_W +: LANES*IN_W]),
            .sum (sum_q[c])
        );
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                acc_i[c] <= '0;
                acc_q[c] <= '0;
            end
            i_val_r    <= '0;
            q_val_r    <= '0;
            iq_valid_r <= 1'b0;
        end else begin
            iq_valid_r <= load_out;
            for (int unsigned c = 0; c < NCH; c++) begin
                if (clear_acc) begin
                    acc_i[c] <= '0;
                    acc_q[c] <= '0;
                end else if (beat_d1) begin
                    acc_i[c] <= acc_i[c] + sum_i[c];
                    acc_q[c] <= acc_q[c] + sum_q[c];
                end
                if (load_out) begin
                    i_val_r[c*ACC_W +: ACC_W] <= acc_i[c];
                    q_val_r[c*ACC_W +: ACC_W] <= acc_q[c];
                end
            end
        end
    end

`ifdef READOUT_THRESH_EN
    logic [NCH-1:0] state_bit_r;

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state_bit_r <= '0;
        end else if (load_out) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                state_bit_r[c] <= acc_i[c] > $signed(io.thresh_i[c*ACC_W +: ACC_W]);
            end
        end
    end

    assign io.state_bit = state_bit_r;
`else
    logic unused_thresh;
    assign unused_thresh = ^io.thresh_i;
    assign io.state_bit  = '0;
`endif

    assign io.busy     = busy_c;
    assign io.overrun  = overrun_r;
    assign io.iq_valid = iq_valid_r;
    assign io.i_val    = i_val_r;
    assign io.q_val    = q_val_r;

endmodule
